// File: rtl/muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_pkg
// Shared ALU op-code encoding plus the sequential multiply/divide constants:
// controller state encoding, iteration count and the bypass classifier.
// No ports (package).
// -----------------------------------------------------------------------------
package muldiv_seq_pkg;

   localparam int unsigned MULDIV_WIDTH = 32;
   // One quotient or multiplier bit per CALC cycle.
   localparam int unsigned MULDIV_ITER  = 32;

   // Shared ALU op encoding; only MUL, DIV and REM are handled by muldiv_seq.
   typedef enum logic [3:0] {
      ALU_ADD = 4'h0,
      ALU_SUB = 4'h1,
      ALU_AND = 4'h2,
      ALU_OR  = 4'h3,
      ALU_XOR = 4'h4,
      ALU_SLL = 4'h5,
      ALU_SRL = 4'h6,
      ALU_SRA = 4'h7,
      ALU_MUL = 4'h8,
      ALU_DIV = 4'h9,
      ALU_REM = 4'hA
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   // True when the operation skips the iterative datapath and finishes after
   // a single CALC cycle (unsupported op, divide by zero, single-cycle MUL).
   function automatic logic needs_bypass(input logic [3:0] op,
                                         input logic       divisor_zero,
                                         input logic       fast_mul);
      logic bypass;
      case (op)
         ALU_MUL:          bypass = fast_mul;
         ALU_DIV, ALU_REM: bypass = divisor_zero;
         default:          bypass = 1'b1;
      endcase
      return bypass;
   endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// muldiv_seq_if
// Request/response bundle of the sequential multiply/divide unit.
//   start, alu_op, in1, in2, kill : requester -> unit
//   ready, busy, done, result, overflow, div_zero : unit -> requester
// Modports: master (requester side), slave (muldiv_seq side).
// -----------------------------------------------------------------------------
interface muldiv_seq_if;
   import muldiv_seq_pkg::*;

   logic                    start;
   logic [3:0]              alu_op;
   logic [MULDIV_WIDTH-1:0] in1;
   logic [MULDIV_WIDTH-1:0] in2;
   logic                    kill;
   logic                    ready;
   logic                    busy;
   logic                    done;
   logic [MULDIV_WIDTH-1:0] result;
   logic                    overflow;
   logic                    div_zero;

   modport master (
      output start, alu_op, in1, in2, kill,
      input  ready, busy, done, result, overflow, div_zero
   );

   modport slave (
      input  start, alu_op, in1, in2, kill,
      output ready, busy, done, result, overflow, div_zero
   );

endinterface

// File: rtl/muldiv_div_step.sv
// -----------------------------------------------------------------------------
// muldiv_div_step
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
// Ports:
//   rem_i          partial remainder before the step (always < divisor_i)
//   dividend_bit_i next dividend bit, MSB first
//   divisor_i      divisor (non-zero)
//   rem_o          partial remainder after the step
//   q_bit_o        quotient bit produced by the step
// -----------------------------------------------------------------------------
module muldiv_div_step
   import muldiv_seq_pkg::*;
(
   input  logic [MULDIV_WIDTH-1:0] rem_i,
   input  logic                    dividend_bit_i,
   input  logic [MULDIV_WIDTH-1:0] divisor_i,
   output logic [MULDIV_WIDTH-1:0] rem_o,
   output logic                    q_bit_o
);

   logic [MULDIV_WIDTH:0]   shifted_s;
   logic [MULDIV_WIDTH-1:0] diff_s;

   // Compare/subtract; rem_i < divisor_i keeps the difference within 32 bits,
   // so the low-word subtraction is exact whenever the divisor fits.
   always_comb begin
      shifted_s = {rem_i, dividend_bit_i};
      diff_s    = shifted_s[MULDIV_WIDTH-1:0] - divisor_i;
      if (shifted_s >= {1'b0, divisor_i}) begin
         q_bit_o = 1'b1;
         rem_o   = diff_s;
      end else begin
         q_bit_o = 1'b0;
         rem_o   = shifted_s[MULDIV_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Sequential unsigned 32-bit multiply / divide / remainder unit.
// MUL: shift-add, one multiplier bit per cycle. DIV/REM: restoring division,
// one quotient bit per cycle. Divide-by-zero and unsupported op codes bypass
// the iteration and complete after one CALC cycle.
// Ports:
//   clk  clock (rising edge)
//   rst  synchronous active-high reset
//   bus  muldiv_seq_if.slave: start/alu_op/in1/in2/kill in,
//        ready/busy/done/result/overflow/div_zero out (all registered)
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle 32x32 MUL that
// bypasses the iteration; DIV/REM are unaffected.
// -----------------------------------------------------------------------------
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32   // only 32 is supported
) (
   input  logic               clk,
   input  logic               rst,
   muldiv_seq_if.slave        bus
);

`ifdef MULDIV_FAST_MUL_EN
   localparam logic FAST_MUL = 1'b1;
`else
   localparam logic FAST_MUL = 1'b0;
`endif

   localparam logic [4:0] LAST_CNT = 5'(MULDIV_ITER - 1);

   muldiv_state_e          state_q, state_d;
   logic [4:0]             cnt_q, cnt_d;
   logic [3:0]             op_q, op_d;
   logic [WIDTH-1:0]       op1_q, op1_d;
   logic [WIDTH-1:0]       op2_q, op2_d;
   // MUL: {partial product high, remaining multiplier bits}
   // DIV: {partial remainder, remaining dividend bits / quotient bits}
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]       result_q, result_d;
   logic                   ovf_q, ovf_d;
   logic                   dz_q, dz_d;
   logic                   ready_q, busy_q, done_q;

   logic [WIDTH:0]         mul_sum_s;
   logic [2*WIDTH-1:0]     mul_acc_s;
   logic [WIDTH-1:0]       div_rem_s;
   logic                   div_qbit_s;
   logic [2*WIDTH-1:0]     div_acc_s;
   logic                   bypass_s;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0]     fast_prod_s;
`endif

   muldiv_div_step u_div_step (
      .rem_i          (acc_q[2*WIDTH-1:WIDTH]),
      .dividend_bit_i (acc_q[WIDTH-1]),
      .divisor_i      (op2_q),
      .rem_o          (div_rem_s),
      .q_bit_o        (div_qbit_s)
   );

   // Datapath step candidates; the multiplier LSB decides whether to add,
   // then the 65-bit sum shifts right by one into the 64-bit accumulator.
   always_comb begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc_q[0]}} & {1'b0, op1_q});
      mul_acc_s = {mul_sum_s, acc_q[WIDTH-1:1]};
      div_acc_s = {div_rem_s, acc_q[WIDTH-2:0], div_qbit_s};
      bypass_s  = needs_bypass(op_q, (op2_q == {WIDTH{1'b0}}), FAST_MUL);
`ifdef MULDIV_FAST_MUL_EN
      fast_prod_s = {{WIDTH{1'b0}}, op1_q} * {{WIDTH{1'b0}}, op2_q};
`endif
   end

   // Next-state and datapath control; kill overrides everything except rst.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      acc_d    = acc_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      dz_d     = dz_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_CALC;
               cnt_d   = 5'd0;
               op_d    = bus.alu_op;
               op1_d   = bus.in1;
               op2_d   = bus.in2;
               if (bus.alu_op == ALU_MUL) begin
                  acc_d = {{WIDTH{1'b0}}, bus.in2};
               end else begin
                  acc_d = {{WIDTH{1'b0}}, bus.in1};
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_CALC: begin
            if (bypass_s) begin
               state_d = ST_DONE;
               cnt_d   = 5'd0;
               case (op_q)
                  ALU_DIV: begin
                     result_d = {WIDTH{1'b1}};
                     ovf_d    = 1'b0;
                     dz_d     = 1'b1;
                  end
                  ALU_REM: begin
                     result_d = op1_q;
                     ovf_d    = 1'b0;
                     dz_d     = 1'b1;
                  end
`ifdef MULDIV_FAST_MUL_EN
                  ALU_MUL: begin
                     result_d = fast_prod_s[WIDTH-1:0];
                     ovf_d    = |fast_prod_s[2*WIDTH-1:WIDTH];
                     dz_d     = 1'b0;
                  end
`endif
                  default: begin
                     result_d = op1_q;
                     ovf_d    = 1'b0;
                     dz_d     = 1'b0;
                  end
               endcase
            end else begin
               if (op_q == ALU_MUL) begin
                  acc_d = mul_acc_s;
               end else begin
                  acc_d = div_acc_s;
               end
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_DONE;
                  cnt_d   = 5'd0;
                  case (op_q)
                     ALU_MUL: begin
                        result_d = acc_d[WIDTH-1:0];
                        ovf_d    = |acc_d[2*WIDTH-1:WIDTH];
                        dz_d     = 1'b0;
                     end
                     ALU_REM: begin
                        result_d = acc_d[2*WIDTH-1:WIDTH];
                        ovf_d    = 1'b0;
                        dz_d     = 1'b0;
                     end
                     default: begin
                        result_d = acc_d[WIDTH-1:0];
                        ovf_d    = 1'b0;
                        dz_d     = 1'b0;
                     end
                  endcase
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
         end
      endcase

      // Flush: drop the operation and keep the previously reported result.
      if (bus.kill) begin
         state_d  = ST_IDLE;
         cnt_d    = 5'd0;
         result_d = result_q;
         ovf_d    = ovf_q;
         dz_d     = dz_q;
      end else begin
         cnt_d = cnt_d;
      end
   end

   // State, datapath and output registers; status flags follow the next state
   // so they are aligned with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 5'd0;
         op_q     <= 4'd0;
         op1_q    <= {WIDTH{1'b0}};
         op2_q    <= {WIDTH{1'b0}};
         acc_q    <= {(2*WIDTH){1'b0}};
         result_q <= {WIDTH{1'b0}};
         ovf_q    <= 1'b0;
         dz_q     <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         dz_q     <= dz_d;
         ready_q  <= (state_d == ST_IDLE);
         busy_q   <= (state_d != ST_IDLE);
         done_q   <= (state_d == ST_DONE);
      end
   end

   assign bus.ready    = ready_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.overflow = ovf_q;
   assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Directed vector table for MUL/DIV/REM/bypass cases plus hand sequences for
// kill, start-while-busy and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int NV = 17;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ovf;
      logic        dz;
      int          lat;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   muldiv_seq_if bus_if ();

   muldiv_seq #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Issue one op, scramble the inputs afterwards, and check done timing and outputs.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic ovf,
                         input logic dz, input int lat);
      int seen;
      seen = 0;
      check({tag, "_ready_before"}, {31'd0, bus_if.ready}, 32'd1);
      bus_if.alu_op = op;
      bus_if.in1    = a;
      bus_if.in2    = b;
      bus_if.start  = 1'b1;
      tick();
      bus_if.start  = 1'b0;
      bus_if.alu_op = 4'hF;
      bus_if.in1    = 32'hDEAD_BEEF;
      bus_if.in2    = 32'h0000_0003;
      for (int k = 1; k <= 40 && seen == 0; k++) begin
         if (bus_if.done === 1'b1) seen = k;
         else tick();
      end
      if (seen == 0) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         check({tag, "_latency"}, 32'(seen), 32'(lat));
         check({tag, "_result"}, bus_if.result, res);
         check({tag, "_overflow"}, {31'd0, bus_if.overflow}, {31'd0, ovf});
         check({tag, "_div_zero"}, {31'd0, bus_if.div_zero}, {31'd0, dz});
         tick();
         check({tag, "_done_single"}, {31'd0, bus_if.done}, 32'd0);
         check({tag, "_ready_after"}, {31'd0, bus_if.ready}, 32'd1);
         check({tag, "_result_hold"}, bus_if.result, res);
      end
   endtask

   vec_t vecs [NV];

   initial begin
      int n_done;
      int seen;
      checks   = 0;
      failures = 0;
      rst           = 1'b1;
      bus_if.start  = 1'b0;
      bus_if.kill   = 1'b0;
      bus_if.alu_op = 4'h0;
      bus_if.in1    = 32'd0;
      bus_if.in2    = 32'd0;

      vecs[0]  = '{ALU_MUL, 32'd7,          32'd6,          32'd42,         1'b0, 1'b0, MUL_LAT};
      vecs[1]  = '{ALU_MUL, 32'h8000_0000,  32'd2,          32'h0000_0000,  1'b1, 1'b0, MUL_LAT};
      vecs[2]  = '{ALU_MUL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b1, 1'b0, MUL_LAT};
      vecs[3]  = '{ALU_MUL, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  1'b1, 1'b0, MUL_LAT};
      vecs[4]  = '{ALU_MUL, 32'd12345,      32'd0,          32'd0,          1'b0, 1'b0, MUL_LAT};
      vecs[5]  = '{ALU_MUL, 32'h0001_0001,  32'h0000_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, MUL_LAT};
      vecs[6]  = '{ALU_DIV, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0, 33};
      vecs[7]  = '{ALU_REM, 32'd100,        32'd7,          32'd2,          1'b0, 1'b0, 33};
      vecs[8]  = '{ALU_DIV, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b1, 2};
      vecs[9]  = '{ALU_REM, 32'd5,          32'd0,          32'd5,          1'b0, 1'b1, 2};
      vecs[10] = '{ALU_DIV, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0, 33};
      vecs[11] = '{ALU_REM, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0000_000F,  1'b0, 1'b0, 33};
      vecs[12] = '{ALU_DIV, 32'd3,          32'd10,         32'd0,          1'b0, 1'b0, 33};
      vecs[13] = '{ALU_DIV, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, 33};
      vecs[14] = '{ALU_ADD, 32'h0000_1234,  32'h0000_5678,  32'h0000_1234,  1'b0, 1'b0, 2};
      vecs[15] = '{4'hF,    32'hCAFE_F00D,  32'd0,          32'hCAFE_F00D,  1'b0, 1'b0, 2};
      vecs[16] = '{ALU_REM, 32'd3,          32'd10,         32'd3,          1'b0, 1'b0, 33};

      // Reset state
      tick(); tick(); tick();
      rst = 1'b0;
      check("rst_ready",    {31'd0, bus_if.ready},    32'd1);
      check("rst_busy",     {31'd0, bus_if.busy},     32'd0);
      check("rst_done",     {31'd0, bus_if.done},     32'd0);
      check("rst_result",   bus_if.result,            32'd0);
      check("rst_overflow", {31'd0, bus_if.overflow}, 32'd0);
      check("rst_div_zero", {31'd0, bus_if.div_zero}, 32'd0);

      // Vector table
      for (int i = 0; i < NV; i++) begin
         run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].ovf, vecs[i].dz, vecs[i].lat);
      end

      // Kill has priority over start in the same cycle
      bus_if.alu_op = ALU_DIV; bus_if.in1 = 32'd100; bus_if.in2 = 32'd7;
      bus_if.start = 1'b1; bus_if.kill = 1'b1;
      tick();
      bus_if.start = 1'b0; bus_if.kill = 1'b0;
      check("killprio_ready", {31'd0, bus_if.ready}, 32'd1);
      check("killprio_busy",  {31'd0, bus_if.busy},  32'd0);

      // Kill at N+10, restart at N+11, second op done at N+44
      bus_if.alu_op = ALU_DIV; bus_if.in1 = 32'd100; bus_if.in2 = 32'd7;
      bus_if.start = 1'b1;
      tick();                                   // N+1
      bus_if.start = 1'b0;
      n_done = 0;
      for (int k = 1; k < 10; k++) begin
         if (bus_if.done === 1'b1) n_done++;
         tick();
      end                                       // N+10
      bus_if.kill = 1'b1;
      if (bus_if.done === 1'b1) n_done++;
      tick();                                   // N+11
      bus_if.kill = 1'b0;
      check("kill_ready", {31'd0, bus_if.ready}, 32'd1);
      bus_if.alu_op = ALU_DIV; bus_if.in1 = 32'd1000; bus_if.in2 = 32'd7;
      bus_if.start = 1'b1;
      if (bus_if.done === 1'b1) n_done++;
      tick();                                   // N+12
      bus_if.start = 1'b0;
      for (int k = 12; k < 44; k++) begin
         if (bus_if.done === 1'b1) n_done++;
         tick();
      end                                       // N+44
      check("kill_no_early_done", 32'(n_done), 32'd0);
      check("kill_second_done",   {31'd0, bus_if.done}, 32'd1);
      check("kill_second_result", bus_if.result, 32'd142);
      tick();

      // start while busy is ignored: one done only, with the first op's result
      bus_if.alu_op = ALU_DIV; bus_if.in1 = 32'd100; bus_if.in2 = 32'd7;
      bus_if.start = 1'b1;
      tick();                                   // N+1
      bus_if.start = 1'b0;
      tick(); tick();                           // N+3
      bus_if.alu_op = ALU_MUL; bus_if.in1 = 32'd7; bus_if.in2 = 32'd6;
      bus_if.start = 1'b1;
      tick();                                   // N+4
      bus_if.start = 1'b0;
      seen = 0;
      n_done = 0;
      for (int k = 4; k < 80; k++) begin
         if (bus_if.done === 1'b1) begin
            n_done++;
            if (seen == 0) begin
               seen = k;
               check("busy_result", bus_if.result, 32'd14);
            end
         end
         tick();
      end
      check("busy_latency",    32'(seen),   32'd33);
      check("busy_done_count", 32'(n_done), 32'd1);

      // rst mid-operation with an ignored start at N+3
      bus_if.alu_op = ALU_DIV; bus_if.in1 = 32'd100; bus_if.in2 = 32'd7;
      bus_if.start = 1'b1;
      tick();                                   // N+1
      bus_if.start = 1'b0;
      tick(); tick();                           // N+3
      bus_if.alu_op = ALU_MUL; bus_if.start = 1'b1;
      tick();                                   // N+4
      bus_if.start = 1'b0;
      tick();                                   // N+5
      rst = 1'b1;
      tick();                                   // N+6
      rst = 1'b0;
      check("midrst_ready",    {31'd0, bus_if.ready},    32'd1);
      check("midrst_busy",     {31'd0, bus_if.busy},     32'd0);
      check("midrst_result",   bus_if.result,            32'd0);
      check("midrst_div_zero", {31'd0, bus_if.div_zero}, 32'd0);
      n_done = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus_if.done === 1'b1) n_done++;
         tick();
      end
      check("midrst_no_done",     32'(n_done), 32'd0);
      check("midrst_ready_later", {31'd0, bus_if.ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-003 Port: clk  in  1  clock; all state changes on the rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: start  in  1  request; the operation is accepted on a cycle where start=1 and ready=1.
REQ-006 Port: alu_op  in  4  operation code from the shared ALU op encoding: MUL, DIV or REM; any other code is "unsupported".
REQ-007 Port: in1  in  32  dividend or multiplicand, unsigned.
REQ-008 Port: in2  in  32  divisor or multiplier, unsigned.
REQ-009 Port: kill  in  1  pipeline flush; aborts any in-flight operation.
REQ-010 Port: ready  out  1  high only in IDLE.
REQ-011 Port: busy  out  1  high while an operation is in flight (not IDLE).
REQ-012 Port: done  out  1  one-cycle pulse; result, overflow and div_zero are valid on this cycle.
REQ-013 Port: result  out  32  product low word, quotient or remainder.
REQ-014 Port: overflow  out  1  MUL: high product word non-zero; DIV/REM: 0.
REQ-015 Port: div_zero  out  1  DIV/REM with in2=0.

Function
REQ-016 States SHALL be IDLE, CALC and DONE.
- IDLE->CALC on acceptance.
- CALC->DONE when the iteration counter reaches 31, or immediately for bypass cases.
- DONE->IDLE unconditionally.
REQ-017 Operands and alu_op SHALL be registered on acceptance; later input changes have no effect on the operation.
REQ-018 MUL SHALL use iterative shift-add, one multiplier bit per cycle, with a 64-bit accumulator.
- result = product[31:0]; overflow = |product[63:32].
REQ-019 DIV/REM SHALL use restoring shift-subtract, one quotient bit per cycle.
- DIV returns the quotient; REM returns the remainder.
REQ-020 Latency: acceptance at cycle N SHALL give done=1 at cycle N+33 (32 CALC cycles plus DONE); ready returns at N+34.
REQ-021 Divide by zero bypass: done at N+2, div_zero=1.
- DIV result = 0xFFFFFFFF; REM result = in1.
REQ-022 Unsupported op bypass: done at N+2, result = in1, overflow=0, div_zero=0.
REQ-023 start while busy SHALL be ignored; no queueing.
REQ-024 kill in any state SHALL force IDLE on the next edge with no done pulse; kill has priority over start in the same cycle.
REQ-025 result, overflow and div_zero SHALL hold their last DONE values until the next DONE.
REQ-026 done SHALL never be high on two consecutive cycles.

Reset
REQ-027 rst SHALL force the state to IDLE and the counter to 0.
- Outputs after reset: result=0, overflow=0, div_zero=0, done=0, busy=0, ready=1.
REQ-028 rst asserted mid-operation SHALL discard the operation, with no done pulse; rst overrides kill and start.

Configuration
REQ-029 Macro MULDIV_FAST_MUL_EN:
- Defined: MUL uses a single-cycle 32x32 multiply, goes straight to DONE and gives done at N+2.
- Undefined: iterative MUL per REQ-018 and REQ-020.
- DIV/REM behaviour is identical in both builds.

Structure
REQ-030 The op codes (MUL, DIV, REM) SHALL come from the shared ALU op-code header/package; the state encodings and the iteration count constant (32) SHALL live in that same shared package.
REQ-031 The divider datapath SHALL be a sub-module, muldiv_div_step (one restoring step: partial remainder and quotient bit), instantiated once.

Verification
REQ-032 MUL in1=7, in2=6 -> done at N+33 (N+2 with MULDIV_FAST_MUL_EN), result=42, overflow=0.
REQ-033 MUL in1=0x80000000, in2=2 -> result=0x00000000, overflow=1.
REQ-034 DIV in1=100, in2=7 -> result=14 at N+33; REM same operands -> result=2; div_zero=0.
REQ-035 DIV in1=5, in2=0 -> done at N+2, result=0xFFFFFFFF, div_zero=1; REM in1=5, in2=0 -> result=5.
REQ-036 Start DIV 100/7, assert kill at N+10, start again at N+11 -> no done from the first op; second op done at N+44 with a correct result.
REQ-037 Start DIV, assert rst at N+5, and pulse start at N+3 while busy -> the N+3 start is ignored; after reset ready=1, result=0 and no done pulse occurs.
